// File: rtl/fetch_unit_if.sv
// Instruction-memory request/grant/response bundle between fetch and imem.
// master: fetch side drives imem_req/imem_addr, samples imem_gnt/imem_rvalid/imem_rdata.
// slave : memory side, mirror image of master.
interface fetch_unit_if #(
    parameter int BITS       = 8,
    parameter int INSTR_BITS = 8
);
    logic                  imem_req;
    logic [BITS-1:0]       imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [INSTR_BITS-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// PC register and instruction-fetch stage: fetches the word at pc, presents it to decode.
// Latency: request to instr_valid is 2 cycles minimum (grant, then rvalid); one fetch per advance.
// Backpressure: request held with stable address until imem_gnt; advance is blocked while stall.
// Ports: clk/rst_n (sync active-low); next_pc/advance/stall/halt from the core;
//        imem (master modport) memory handshake; pc/pc_inc/instr/instr_valid/halted outputs.
module fetch_unit #(
    parameter int              BITS       = 8,
    parameter int              INSTR_BITS = 8,
    parameter logic [BITS-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BITS-1:0]       next_pc,
    input  logic                  advance,
    input  logic                  stall,
    input  logic                  halt,
    fetch_unit_if.master          imem,
    output logic [BITS-1:0]       pc,
    output logic [BITS-1:0]       pc_inc,
    output logic [INSTR_BITS-1:0] instr,
    output logic                  instr_valid,
    output logic                  halted
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_READY = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [BITS-1:0]       pc_q, pc_d;
    logic [INSTR_BITS-1:0] instr_q, instr_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  halted_q, halted_d;
    logic                  accept;

    // Decode may only consume the instruction when it is not stalled.
    assign accept = advance && !stall;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            // One dead cycle after reset release before the first request.
            S_IDLE:  state_d = S_REQ;
            S_REQ:   if (imem.imem_gnt) state_d = S_WAIT;
            S_WAIT:  if (imem.imem_rvalid) state_d = S_READY;
            S_READY: if (accept) state_d = halt ? S_HALT : S_REQ;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: request is a pure function of state, address always tracks pc.
    always_comb begin
        imem.imem_req  = (state_q == S_REQ);
        imem.imem_addr = pc_q;
    end

    // Datapath next-state: responses are only taken in WAIT, so a stray rvalid
    // after reset or after halt never reaches instr.
    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        case (state_q)
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    instr_d       = imem.imem_rdata;
                    instr_valid_d = 1'b1;
                end
            end
            S_READY: begin
                if (accept) begin
                    instr_valid_d = 1'b0;
                    // On halt the pc keeps pointing at the halting instruction.
                    if (halt) begin
                        halted_d = 1'b1;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign pc          = pc_q;
    assign pc_inc      = pc_q + BITS'(1);
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed walk through the fetch scenarios,
// then randomized stimulus against a transaction-level reference model.
// Outputs are sampled at the falling edge, away from the active rising edge.
module tb_fetch_unit;

    localparam int BITS       = 8;
    localparam int INSTR_BITS = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [BITS-1:0]       next_pc;
    logic                  advance, stall, halt;
    logic [BITS-1:0]       pc, pc_inc;
    logic [INSTR_BITS-1:0] instr;
    logic                  instr_valid, halted;

    fetch_unit_if #(.BITS(BITS), .INSTR_BITS(INSTR_BITS)) imem_if ();

    fetch_unit #(.BITS(BITS), .INSTR_BITS(INSTR_BITS), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .next_pc     (next_pc),
        .advance     (advance),
        .stall       (stall),
        .halt        (halt),
        .imem        (imem_if),
        .pc          (pc),
        .pc_inc      (pc_inc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: what the fetch stage has done so far, in transaction terms.
    logic [7:0] m_pc, m_instr;
    bit         m_valid, m_halted;
    bit         m_dead;     // post-reset dead cycle still pending
    bit         m_granted;  // request accepted, response outstanding

    function automatic bit m_requesting();
        return !m_dead && !m_halted && !m_valid && !m_granted;
    endfunction

    task automatic model_reset();
        m_pc = 8'h00; m_instr = 8'h00; m_valid = 0; m_halted = 0;
        m_dead = 1; m_granted = 0;
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else if (m_dead) begin
            m_dead = 0;
        end else if (m_halted) begin
            // frozen
        end else if (m_requesting()) begin
            if (imem_if.imem_gnt) m_granted = 1;
        end else if (m_granted) begin
            if (imem_if.imem_rvalid) begin
                m_instr = imem_if.imem_rdata; m_valid = 1; m_granted = 0;
            end
        end else if (m_valid && advance && !stall) begin
            m_valid = 0;
            if (halt) m_halted = 1;
            else      m_pc = next_pc;
        end
    endtask

    task automatic model_check();
        chk_eq("pc",          pc,                 m_pc);
        chk_eq("pc_inc",      pc_inc,             m_pc + 8'h01);
        chk_eq("instr",       instr,              m_instr);
        chk_eq("instr_valid", 8'(instr_valid),    8'(m_valid));
        chk_eq("halted",      8'(halted),         8'(m_halted));
        chk_eq("imem_req",    8'(imem_if.imem_req), 8'(m_requesting()));
        chk_eq("imem_addr",   imem_if.imem_addr,  m_pc);
    endtask

    // One clock: apply inputs just after a falling edge, check, step model on the
    // rising edge, return at the next falling edge with new state visible.
    task automatic cyc(input logic r, input logic g, input logic rv, input logic [7:0] rd,
                       input logic adv, input logic st, input logic hl, input logic [7:0] np);
        rst_n = r; imem_if.imem_gnt = g; imem_if.imem_rvalid = rv; imem_if.imem_rdata = rd;
        advance = adv; stall = st; halt = hl; next_pc = np;
        #1;
        model_check();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; next_pc = '0; advance = 0; stall = 0; halt = 0;
        imem_if.imem_gnt = 0; imem_if.imem_rvalid = 0; imem_if.imem_rdata = '0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);

        // Reset state
        chk_eq("rst pc", pc, 8'h00);
        chk_eq("rst instr", instr, 8'h00);
        chk_eq("rst valid", 8'(instr_valid), 8'h00);
        chk_eq("rst halted", 8'(halted), 8'h00);
        chk_eq("rst req", 8'(imem_if.imem_req), 8'h00);
        chk_eq("rst pc_inc", pc_inc, 8'h01);

        // Dead cycle after release, then request at pc 0 with grant backpressure
        cyc(1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        chk_eq("first req", 8'(imem_if.imem_req), 8'h01);
        chk_eq("first addr", imem_if.imem_addr, 8'h00);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 1, 8'hEE, 1, 0, 0, 8'h10);
            chk_eq("bp req", 8'(imem_if.imem_req), 8'h01);
            chk_eq("bp addr", imem_if.imem_addr, 8'h00);
        end
        cyc(1, 1, 0, 8'h00, 0, 0, 0, 8'h00);
        chk_eq("wait req", 8'(imem_if.imem_req), 8'h00);
        cyc(1, 0, 1, 8'hA5, 0, 0, 0, 8'h00);
        chk_eq("fetch instr", instr, 8'hA5);
        chk_eq("fetch valid", 8'(instr_valid), 8'h01);
        chk_eq("fetch pc_inc", pc_inc, 8'h01);

        // Advance blocked by stall, then released
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 0, 8'h00, 1, 1, 0, 8'h3C);
            chk_eq("stall pc", pc, 8'h00);
            chk_eq("stall valid", 8'(instr_valid), 8'h01);
        end
        cyc(1, 0, 0, 8'h00, 1, 0, 0, 8'h3C);
        chk_eq("adv pc", pc, 8'h3C);
        chk_eq("adv valid", 8'(instr_valid), 8'h00);
        chk_eq("adv req", 8'(imem_if.imem_req), 8'h01);
        chk_eq("adv addr", imem_if.imem_addr, 8'h3C);

        // Wrap at the top of the address space
        cyc(1, 1, 0, 8'h00, 0, 0, 0, 8'h00);
        cyc(1, 0, 1, 8'h11, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'h00, 1, 0, 0, 8'hFF);
        chk_eq("wrap pc_inc", pc_inc, 8'h00);
        chk_eq("wrap addr", imem_if.imem_addr, 8'hFF);
        cyc(1, 1, 0, 8'h00, 0, 0, 0, 8'h00);
        cyc(1, 0, 1, 8'h22, 0, 0, 0, 8'h00);

        // Halt freezes everything
        cyc(1, 0, 0, 8'h00, 1, 0, 1, 8'h40);
        chk_eq("halt halted", 8'(halted), 8'h01);
        chk_eq("halt valid", 8'(instr_valid), 8'h00);
        chk_eq("halt pc", pc, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 1, 8'h99, 1, 0, 0, 8'h40);
            chk_eq("halted req", 8'(imem_if.imem_req), 8'h00);
            chk_eq("halted instr", instr, 8'h22);
        end

        // Reset in the middle of an outstanding fetch, stray response afterwards
        cyc(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        cyc(1, 1, 0, 8'h00, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        chk_eq("mid pc", pc, 8'h00);
        chk_eq("mid instr", instr, 8'h00);
        chk_eq("mid valid", 8'(instr_valid), 8'h00);
        cyc(1, 0, 1, 8'h77, 0, 0, 0, 8'h00);
        chk_eq("stray instr", instr, 8'h00);
        chk_eq("stray valid", 8'(instr_valid), 8'h00);
        chk_eq("restart req", 8'(imem_if.imem_req), 8'h01);
        cyc(1, 1, 0, 8'h00, 0, 0, 0, 8'h00);
        cyc(1, 0, 1, 8'h5A, 0, 0, 0, 8'h00);
        chk_eq("restart instr", instr, 8'h5A);
        chk_eq("restart valid", 8'(instr_valid), 8'h01);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic       r, g, rv, adv, st, hl;
            logic [7:0] rd, np;
            r   = ($urandom_range(0, 99) >= 2);
            g   = ($urandom_range(0, 99) < 50);
            rv  = ($urandom_range(0, 99) < 50);
            rd  = 8'($urandom);
            adv = ($urandom_range(0, 99) < 50);
            st  = ($urandom_range(0, 99) < 30);
            hl  = ($urandom_range(0, 99) < 4);
            np  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            cyc(r, g, rv, rd, adv, st, hl, np);
        end
        #1;
        model_check();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
